// File: rtl/jt89_wrbuf.sv
// Host-side write buffer for the jt89 PSG: queues CPU byte writes in a FIFO and replays
// each one as a clean wr_n low pulse followed by a minimum high gap counted in clk_en ticks.
module jt89_wrbuf #(
    parameter int unsigned DW      = 3,
    parameter int unsigned LOW_CYC = 2,
    parameter int unsigned GAP_CEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          host_wr,
    input  logic [7:0]    host_din,
    input  logic          ovf_clr,
    output logic          psg_wr_n,
    output logic [7:0]    psg_din,
    output logic          empty,
    output logic          full,
    output logic [DW:0]   level,
    output logic          ovf
);

    localparam int unsigned DEPTH = 2**DW;

    typedef enum logic [1:0] {StIdle, StLow, StGap} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW:0]   level_q, level_d;
    logic [3:0]    low_cnt_q, low_cnt_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          wr_n_q, wr_n_d;
    logic [7:0]    din_q, din_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic push, drop, pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == (DW+1)'(DEPTH));

    // full is judged on the registered level, so a pop in the same cycle cannot rescue a write
    assign push = host_wr & ~full;
    assign drop = host_wr & full;
    assign pop  = (state_q == StIdle) & ~empty;

    always_comb begin
        state_d   = state_q;
        low_cnt_d = low_cnt_q;
        gap_cnt_d = gap_cnt_q;
        wr_n_d    = wr_n_q;
        din_d     = din_q;
        rd_ptr_d  = rd_ptr_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    din_d     = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    wr_n_d    = 1'b0;
                    low_cnt_d = '0;
                    state_d   = StLow;
                end
            end
            StLow: begin
                if (low_cnt_q == 4'(LOW_CYC - 1)) begin
                    wr_n_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            StGap: begin
                // only PSG clock ticks count toward the gap the PSG actually observes
                if (clk_en) begin
                    if (gap_cnt_q == 4'(GAP_CEN - 1)) begin
                        state_d = StIdle;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            low_cnt_q <= '0;
            gap_cnt_q <= '0;
            wr_n_q    <= 1'b1;
            din_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            low_cnt_q <= low_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            wr_n_q    <= wr_n_d;
            din_q     <= din_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host_din;
        end
    end

    assign psg_wr_n = wr_n_q;
    assign psg_din  = din_q;
    assign level    = level_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_jt89_wrbuf.sv
// Bench for jt89_wrbuf: a queue/countdown model checked every cycle, plus directed scenarios
// with literal expectations on the replayed byte stream, levels and flags.
module tb_jt89_wrbuf;

    localparam int unsigned DW  = 3;
    localparam int          LOW = 2;
    localparam int          GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_wr = 1'b0;
    logic [7:0] host_din = '0;
    logic       ovf_clr = 1'b0;
    logic       psg_wr_n;
    logic [7:0] psg_din;
    logic       empty, full, ovf;
    logic [DW:0] level;
    wire        clk_en;

    int  total = 0;
    int  bad = 0;
    int  cen_div = 1;
    logic cen_man = 1'b0;
    int  cyc = 0;

    assign clk_en = (cen_div == 0) ? cen_man : ((cyc % cen_div) == 0);

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    jt89_wrbuf #(.DW(DW), .LOW_CYC(LOW), .GAP_CEN(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .host_wr  (host_wr),
        .host_din (host_din),
        .ovf_clr  (ovf_clr),
        .psg_wr_n (psg_wr_n),
        .psg_din  (psg_din),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .ovf      (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: byte queue plus countdowns for the remaining low cycles / gap ticks.
    logic [7:0] mq[$];
    logic       m_wr_n = 1'b1;
    logic [7:0] m_din = '0;
    logic       m_ovf = 1'b0;
    int         low_left = 0;
    int         gap_left = 0;

    task automatic model_step();
        bit was_full;
        if (rst) begin
            mq.delete();
            m_wr_n = 1'b1; m_din = '0; m_ovf = 1'b0; low_left = 0; gap_left = 0;
        end else begin
            was_full = (mq.size() == 8);
            if (low_left > 0) begin
                low_left--;
                if (low_left == 0) begin
                    m_wr_n = 1'b1;
                    gap_left = GAP;
                end
            end else if (gap_left > 0) begin
                if (clk_en) gap_left--;
            end else if (mq.size() > 0) begin
                m_din = mq.pop_front();
                m_wr_n = 1'b0;
                low_left = LOW;
            end
            if (host_wr && !was_full) mq.push_back(host_din);
            if (host_wr && was_full) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    endtask

    bit         chk_en = 0;
    logic [7:0] out_log[$];
    logic [7:0] exp_log[$];
    logic       prev_wr_n = 1'b1;
    int         hi_ticks = 0;
    bit         seen = 0;
    int         peak = 0;

    always @(posedge clk) begin
        if (prev_wr_n && clk_en) hi_ticks++;
        model_step();
        #1;
        if (chk_en) begin
            chk("wr_n", psg_wr_n, m_wr_n);
            chk("din", psg_din, m_din);
            chk("level", level, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == 8);
            chk("ovf", ovf, m_ovf);
            if (prev_wr_n === 1'b1 && psg_wr_n === 1'b0) begin
                if (seen) chk("gap_ticks", hi_ticks >= GAP, 1);
                seen = 1;
                out_log.push_back(psg_din);
            end
            if (int'(level) > peak) peak = int'(level);
        end
        if (rst) begin
            seen = 0;
            hi_ticks = 0;
        end
        if (psg_wr_n === 1'b0) hi_ticks = 0;
        prev_wr_n = psg_wr_n;
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] d);
        host_wr = 1'b1;
        host_din = d;
        @(negedge clk);
        host_wr = 1'b0;
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_len"}, out_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
            chk({nm, "_byte"}, out_log[i], exp_log[i]);
        out_log.delete();
        exp_log.delete();
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cycles(3);
        chk_en = 1;
        chk("rst_wr_n", psg_wr_n, 1);
        chk("rst_din", psg_din, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        cycles(2);

        // Single write: pulse starts one cycle after the push and lasts two cycles
        cen_div = 1;
        write(8'h9F);
        chk("t1_push_wr_n", psg_wr_n, 1);
        chk("t1_push_level", level, 1);
        cycles(1);
        chk("t1_low0", psg_wr_n, 0);
        chk("t1_din0", psg_din, 8'h9F);
        chk("t1_empty", empty, 1);
        cycles(1);
        chk("t1_low1", psg_wr_n, 0);
        chk("t1_din1", psg_din, 8'h9F);
        cycles(1);
        chk("t1_high", psg_wr_n, 1);
        chk("t1_din_hold", psg_din, 8'h9F);
        cycles(10);
        exp_log = '{8'h9F};
        chk_log("t1_log");

        // Five back-to-back writes with clk_en every 4th cycle
        cen_div = 4;
        peak = 0;
        write(8'h80); write(8'h0A); write(8'h90); write(8'hA5); write(8'hFF);
        cycles(120);
        chk("t2_peak", peak, 4);
        exp_log = '{8'h80, 8'h0A, 8'h90, 8'hA5, 8'hFF};
        chk_log("t2_log");

        // Stall in the gap with clk_en low, then overfill
        cen_div = 0;
        cen_man = 1'b0;
        write(8'h11);
        cycles(5);
        for (int i = 0; i < 9; i++) write(8'(8'h21 + i));
        chk("t3_level", level, 8);
        chk("t3_full", full, 1);
        chk("t3_ovf", ovf, 1);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", ovf, 0);

        // Release the gap so the pop lands on the same edge as a write into the full FIFO
        cen_man = 1'b1;
        cycles(2);
        cen_man = 1'b0;
        write(8'h5A);
        chk("t4_level", level, 7);
        chk("t4_ovf", ovf, 1);
        chk("t4_wr_n", psg_wr_n, 0);
        chk("t4_din", psg_din, 8'h21);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        cen_div = 1;
        cycles(80);
        chk("t4_drained", level, 0);
        exp_log = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        chk_log("t3_log");

        // Reset in the middle of a pulse with three entries queued
        cen_div = 0;
        cen_man = 1'b0;
        for (int i = 0; i < 5; i++) write(8'(8'hC0 + i));
        cycles(4);
        cen_man = 1'b1;
        begin
            int n = 0;
            while (psg_wr_n !== 1'b0 && n < 50) begin
                cycles(1);
                n++;
            end
            chk("t5_wait_low", n < 50, 1);
        end
        chk("t5_level_pre", level, 3);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("t5_wr_n", psg_wr_n, 1);
        chk("t5_level", level, 0);
        chk("t5_empty", empty, 1);
        cen_div = 1;
        out_log.delete();
        cycles(40);
        chk("t5_no_pulse", out_log.size(), 0);
        out_log.delete();

        // Twenty spread writes to wrap the pointers
        cen_div = 1;
        for (int i = 0; i < 20; i++) begin
            write(8'(i * 37 + 5));
            exp_log.push_back(8'(i * 37 + 5));
            cycles(3);
        end
        cycles(150);
        chk("t6_level", level, 0);
        chk_log("t6_log");

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jt89_wrbuf.md
Name: jt89_wrbuf

Overview:
- Host-side write buffer sitting directly upstream of the jt89 PSG core.
- Accepts single-cycle byte-write strobes from the CPU bus and queues them in a FIFO; back-to-back writes are allowed.
- Replays each byte to the PSG as a clean wr_n low pulse with stable data.
- Between pulses it enforces a minimum high gap measured in clk_en ticks, so the PSG's falling-edge write detector never misses or merges writes.

Parameters:
- DW, 3: log2 of FIFO depth (depth = 2**DW = 8 entries).
- LOW_CYC, 2: clk cycles psg_wr_n is held low per write; legal range 1..15.
- GAP_CEN, 2: clk_en pulses psg_wr_n is held high after each write before the next may start; legal range 1..15.

Ports:
- clk  in  1  system clock, shared with the PSG.
- rst  in  1  synchronous reset, active-high.
- clk_en  in  1  PSG clock enable, same signal that drives the PSG's clk_en.
- host_wr  in  1  one-cycle write strobe from the CPU bus.
- host_din  in  8  write data, sampled when host_wr=1.
- ovf_clr  in  1  clears the sticky overflow flag.
- psg_wr_n  out  1  write strobe to the PSG, active-low.
- psg_din  out  8  data to the PSG.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds 2**DW entries.
- level  out  DW+1  current entry count.
- ovf  out  1  sticky flag: a host write was dropped.

Behaviour:
- Reset:
  - psg_wr_n=1, psg_din=0, empty=1, full=0, level=0, ovf=0.
  - Read and write pointers go to 0; FSM goes to IDLE; counters go to 0.
  - Reset asserted mid-pulse: psg_wr_n=1 after the next edge and all queued data is discarded.
- All outputs are registered. full and empty are decoded from the registered level.
- Push:
  - host_wr=1 with full=0 in the same cycle: host_din is stored at the write pointer, the pointer advances, level+1.
  - host_wr=1 with full=1: the byte is dropped and ovf is set. This holds even if a pop happens in the same cycle, because full is evaluated before the pop.
- Pointers wrap modulo 2**DW. level ranges 0..2**DW and never wraps.
- ovf clear: ovf_clr=1 clears ovf; if a dropping write and ovf_clr occur in the same cycle, the set wins.
- Simultaneous push and pop (full=0): level is unchanged, both pointers advance.
- FSM is three states: IDLE, LOW, GAP.
- IDLE:
  - If level!=0: on the edge, psg_din<=FIFO[rd_ptr], rd_ptr+1, level-1, psg_wr_n<=0, low counter<=0, go to LOW.
  - Otherwise stay in IDLE.
- LOW:
  - The low counter increments each clk regardless of clk_en.
  - When the counter reaches LOW_CYC-1: psg_wr_n<=1, gap counter<=0, go to GAP.
  - psg_wr_n is therefore low for exactly LOW_CYC clk cycles.
- GAP:
  - The gap counter increments only on cycles with clk_en=1.
  - When clk_en=1 and the counter = GAP_CEN-1: go to IDLE.
- psg_din holds its value from the load edge until the next IDLE load, so it is stable across the whole low pulse and the cycle after it.
- Latency: a push into an empty FIFO while in IDLE at edge N gives psg_wr_n=0 after edge N+1.
- The PSG must never see psg_wr_n high for fewer than GAP_CEN clk_en ticks between pulses.
- clk_en stuck at 0: the FSM stalls in GAP indefinitely and the FIFO keeps accepting writes until full. This is not an error.
- No bypass path: every byte passes through the FIFO.

Test Plan:
- Reset, then single write host_din=0x9F -> psg_wr_n low exactly 2 cycles starting 1 cycle after the push; psg_din=0x9F through the pulse; empty=1 after the pop edge.
- Five back-to-back writes 0x80,0x0A,0x90,0xA5,0xFF with clk_en every 4th cycle -> five pulses in order; each gap ≥2 clk_en ticks; level peaks at 4.
- Nine writes with clk_en=0 (depth 8) -> level=8, full=1, ovf=1, ninth byte absent from the PSG output once clk_en resumes; ovf_clr -> ovf=0.
- Push into a full FIFO in the same cycle a pop leaves IDLE -> write dropped, ovf=1, level 8→7.
- Assert rst while psg_wr_n=0 with 3 entries queued -> next cycle psg_wr_n=1, level=0, no further pulses.
- 20 writes spread over time to force pointer wrap (DW=3) -> output byte sequence equals input sequence exactly.
